// File: rtl/led_pkg.sv
// Shared encodings for the LED flow controller: pattern modes and ping-pong direction.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ROL  = 2'd0,
        MODE_ROR  = 2'd1,
        MODE_PING = 2'd2,
        MODE_FILL = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

endpackage

// File: rtl/led_flow_ctrl_if.sv
// Control/status bundle between a host and the LED flow controller.
interface led_flow_ctrl_if #(
    parameter int LED_NUM = 8
);
    logic [1:0]         mode;
    logic               mode_vld;
    logic               pause;
    logic [1:0]         speed;
    logic [LED_NUM-1:0] led;
    logic               step_pulse;
    logic [1:0]         mode_cur;

    modport master (
        output mode, mode_vld, pause, speed,
        input  led, step_pulse, mode_cur
    );

    modport slave (
        input  mode, mode_vld, pause, speed,
        output led, step_pulse, mode_cur
    );
endinterface

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every DELAY_STEP+1 enabled cycles; clr restarts the count.
module tick_gen #(
    parameter int DELAY_STEP = 49_999_999
) (
    input  logic sclk,
    input  logic s_rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int              CW   = (DELAY_STEP > 0) ? $clog2(DELAY_STEP + 1) : 1;
    localparam logic [CW-1:0]   TERM = CW'(DELAY_STEP);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign tick = en && (cnt_q == TERM);
endmodule

// File: rtl/led_flow_ctrl.sv
// LED pattern sequencer: prescaled base ticks, speed divider, and one registered
// led/dir stage fed by a per-mode next-pattern case.
module led_flow_ctrl
    import led_pkg::*;
#(
    parameter int LED_NUM    = 8,
    parameter int DELAY_STEP = 49_999_999
) (
    input  logic           sclk,
    input  logic           s_rst_n,
    led_flow_ctrl_if.slave bus
);
    localparam logic [LED_NUM-1:0] LED_ONE = LED_NUM'(1);

    mode_e              mode_q, mode_d;
    dir_e               dir_q, dir_d;
    logic [LED_NUM-1:0] led_q, led_d;
    logic [1:0]         spd_q, spd_d;
    logic               pulse_q, pulse_d;
    logic               tick;
    logic               step;
    logic [LED_NUM-1:0] pat_led;
    dir_e               pat_dir;

    tick_gen #(.DELAY_STEP(DELAY_STEP)) u_tick (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .clr     (bus.mode_vld),
        .en      (~bus.pause),
        .tick    (tick)
    );

    // >= rather than == so a speed lowered below the running count steps on the next tick
    assign step = tick && !bus.mode_vld && (spd_q >= bus.speed);

    always_comb begin
        pat_led = led_q;
        pat_dir = dir_q;
        case (mode_q)
            MODE_ROL:  pat_led = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
            MODE_ROR:  pat_led = {led_q[0], led_q[LED_NUM-1:1]};
            MODE_PING: begin
                if (dir_q == DIR_LEFT) begin
                    pat_led = led_q << 1;
                    pat_dir = pat_led[LED_NUM-1] ? DIR_RIGHT : DIR_LEFT;
                end else begin
                    pat_led = led_q >> 1;
                    pat_dir = pat_led[0] ? DIR_LEFT : DIR_RIGHT;
                end
            end
            MODE_FILL: pat_led = (&led_q) ? LED_ONE : {led_q[LED_NUM-2:0], 1'b1};
            default:   pat_led = led_q;
        endcase
    end

    always_comb begin
        mode_d  = mode_q;
        dir_d   = dir_q;
        led_d   = led_q;
        spd_d   = spd_q;
        pulse_d = step;
        if (bus.mode_vld) begin
            mode_d = mode_e'(bus.mode);
            dir_d  = DIR_LEFT;
            led_d  = LED_ONE;
            spd_d  = '0;
        end else if (tick) begin
            if (step) begin
                spd_d = '0;
                led_d = pat_led;
                dir_d = pat_dir;
            end else begin
                spd_d = spd_q + 2'd1;
            end
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            mode_q  <= MODE_ROL;
            dir_q   <= DIR_LEFT;
            led_q   <= LED_ONE;
            spd_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            led_q   <= led_d;
            spd_q   <= spd_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.led        = led_q;
    assign bus.step_pulse = pulse_q & ~bus.pause;
    assign bus.mode_cur   = mode_q;
endmodule

// File: tb/tb_led_flow_ctrl.sv
// Bench for led_flow_ctrl: directed vector table, corner sequences, then random traffic vs a step-count model.
module tb_led_flow_ctrl;
    localparam int N  = 4;
    localparam int DS = 4;

    logic sclk    = 1'b0;
    logic s_rst_n = 1'b0;

    led_flow_ctrl_if #(.LED_NUM(N)) bus();

    led_flow_ctrl #(.LED_NUM(N), .DELAY_STEP(DS)) dut (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .bus     (bus)
    );

    always #5 sclk = ~sclk;

    int total = 0;
    int bad   = 0;

    // Model state: pattern is a pure function of mode and steps taken since restart.
    int m_mode, m_k, m_act, m_tcnt;
    bit m_pulse;

    function automatic logic [N-1:0] pat(input int md, input int k);
        int p;
        logic [N-1:0] one;
        one = 1;
        case (md)
            0: return one << (k % N);
            1: return one << ((N - (k % N)) % N);
            2: begin
                p = k % (2*N - 2);
                return one << ((p < N) ? p : (2*N - 2 - p));
            end
            default: return N'((1 << ((k % N) + 1)) - 1);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_act = 0; m_tcnt = 0; m_pulse = 0;
    endtask

    // Apply the inputs the DUT just sampled at the rising edge.
    task automatic model_edge();
        m_pulse = 0;
        if (!s_rst_n) begin
            model_reset();
        end else if (bus.mode_vld) begin
            m_mode = int'(bus.mode); m_k = 0; m_act = 0; m_tcnt = 0;
        end else if (!bus.pause) begin
            if ((m_act % (DS + 1)) == DS) begin
                if (m_tcnt >= int'(bus.speed)) begin
                    m_k++; m_tcnt = 0; m_pulse = 1;
                end else begin
                    m_tcnt++;
                end
            end
            m_act++;
        end
    endtask

    task automatic model_chk();
        chk("led", 32'(bus.led), 32'(pat(m_mode, m_k)));
        chk("mode_cur", 32'(bus.mode_cur), 32'(m_mode));
        chk("step_pulse", 32'(bus.step_pulse), 32'(m_pulse));
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic cyc(input bit r, input logic [1:0] md, input bit mv, input bit p, input logic [1:0] sp);
        s_rst_n = r; bus.mode = md; bus.mode_vld = mv; bus.pause = p; bus.speed = sp;
        @(posedge sclk);
        model_edge();
        @(negedge sclk);
        model_chk();
    endtask

    task automatic run(input int n, input logic [1:0] md, input logic [1:0] sp);
        for (int i = 0; i < n; i++) cyc(1, md, 0, 0, sp);
    endtask

    typedef struct {
        logic [1:0] md;
        bit         mv;
        logic [1:0] sp;
        int         n;
        logic [3:0] led;
        bit         pl;
        logic [1:0] mc;
    } vec_t;

    vec_t tbl[$];
    bit   rp;
    bit   rr;
    logic [1:0] rmd, rsp;

    initial begin
        bus.mode = 0; bus.mode_vld = 0; bus.pause = 0; bus.speed = 0;
        model_reset();
        @(negedge sclk);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 2, 1, 0, 3);
        chk("rst_led", 32'(bus.led), 32'h1);
        chk("rst_mode", 32'(bus.mode_cur), 32'h0);
        chk("rst_pulse", 32'(bus.step_pulse), 32'h0);

        tbl.push_back('{0, 0, 0, 5, 4'b0010, 1, 0});
        tbl.push_back('{0, 0, 0, 5, 4'b0100, 1, 0});
        tbl.push_back('{0, 0, 0, 5, 4'b1000, 1, 0});
        tbl.push_back('{0, 0, 0, 5, 4'b0001, 1, 0});
        tbl.push_back('{2, 1, 1, 1, 4'b0001, 0, 2});
        tbl.push_back('{2, 0, 1, 10, 4'b0010, 1, 2});
        tbl.push_back('{2, 0, 1, 10, 4'b0100, 1, 2});
        tbl.push_back('{2, 0, 1, 10, 4'b1000, 1, 2});
        tbl.push_back('{2, 0, 1, 10, 4'b0100, 1, 2});
        tbl.push_back('{2, 0, 1, 10, 4'b0010, 1, 2});
        tbl.push_back('{2, 0, 1, 10, 4'b0001, 1, 2});
        tbl.push_back('{3, 1, 0, 1, 4'b0001, 0, 3});
        tbl.push_back('{3, 0, 0, 5, 4'b0011, 1, 3});
        tbl.push_back('{3, 0, 0, 5, 4'b0111, 1, 3});
        tbl.push_back('{3, 0, 0, 5, 4'b1111, 1, 3});
        tbl.push_back('{3, 0, 0, 5, 4'b0001, 1, 3});
        tbl.push_back('{1, 1, 0, 1, 4'b0001, 0, 1});
        tbl.push_back('{1, 0, 0, 5, 4'b1000, 1, 1});
        tbl.push_back('{1, 0, 0, 5, 4'b0100, 1, 1});
        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].n; c++)
                cyc(1, tbl[i].md, (c == 0) ? tbl[i].mv : 1'b0, 0, tbl[i].sp);
            chk($sformatf("vec%0d_led", i), 32'(bus.led), 32'(tbl[i].led));
            chk($sformatf("vec%0d_pulse", i), 32'(bus.step_pulse), 32'(tbl[i].pl));
            chk($sformatf("vec%0d_mode", i), 32'(bus.mode_cur), 32'(tbl[i].mc));
        end

        // step_pulse is masked immediately by pause
        cyc(1, 0, 1, 0, 0);
        run(5, 0, 0);
        bus.pause = 1; #1;
        chk("pause_mask_pulse", 32'(bus.step_pulse), 32'h0);
        bus.pause = 0; #1;
        chk("unpause_pulse", 32'(bus.step_pulse), 32'h1);

        // pause for 13 cycles mid-count delays the step by exactly 13
        cyc(1, 0, 1, 0, 0);
        run(2, 0, 0);
        for (int i = 0; i < 13; i++) begin
            cyc(1, 0, 0, 1, 0);
            chk("pause_led", 32'(bus.led), 32'h1);
            chk("pause_pulse", 32'(bus.step_pulse), 32'h0);
        end
        run(2, 0, 0);
        chk("pause_early", 32'(bus.led), 32'h1);
        run(1, 0, 0);
        chk("pause_step_led", 32'(bus.led), 32'h2);
        chk("pause_step_pulse", 32'(bus.step_pulse), 32'h1);

        // restart coincident with a step wins
        cyc(1, 0, 1, 0, 0);
        run(4, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk("coin_pulse", 32'(bus.step_pulse), 32'h0);
        chk("coin_led", 32'(bus.led), 32'h1);
        chk("coin_mode", 32'(bus.mode_cur), 32'h1);
        run(4, 1, 0);
        chk("coin_hold", 32'(bus.led), 32'h1);
        run(1, 1, 0);
        chk("coin_next", 32'(bus.led), 32'h8);

        // asynchronous reset mid-pattern
        cyc(1, 2, 1, 0, 0);
        run(10, 2, 0);
        chk("pre_rst_led", 32'(bus.led), 32'h4);
        s_rst_n = 0; #1;
        model_reset();
        chk("async_rst_led", 32'(bus.led), 32'h1);
        chk("async_rst_mode", 32'(bus.mode_cur), 32'h0);
        cyc(0, 2, 0, 0, 0);
        run(5, 2, 0);
        chk("post_rst_led", 32'(bus.led), 32'h2);
        chk("post_rst_mode", 32'(bus.mode_cur), 32'h0);

        // random traffic against the model
        rp = 0; rsp = 0; rmd = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) rp = ~rp;
            if ($urandom_range(49) == 0) rsp = 2'($urandom_range(3));
            rmd = 2'($urandom_range(3));
            rr = ($urandom_range(399) != 0);
            cyc(rr, rmd, ($urandom_range(29) == 0), rp, rsp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_flow_ctrl.md
LED_FLOW_CTRL -- requirements
Module: led_flow_ctrl

Interface
REQ-001 SHALL provide parameter LED_NUM, default 8, number of LEDs driven; legal range 2..32.
REQ-002 SHALL provide parameter DELAY_STEP, default 49_999_999, prescaler terminal count; one base tick = DELAY_STEP+1 sclk cycles (1 s at 50 MHz).
REQ-003 SHALL derive the prescaler counter width locally as clog2(DELAY_STEP+1); it is not a user parameter.
REQ-004 sclk  input  1  system clock, 50 MHz nominal.
REQ-005 s_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 mode  input  2  requested pattern: 0 rotate-left, 1 rotate-right, 2 ping-pong, 3 bar-fill.
REQ-007 mode_vld  input  1  single-cycle strobe; latches mode.
REQ-008 pause  input  1  level; high freezes the pattern.
REQ-009 speed  input  2  steps occur every speed+1 base ticks.
REQ-010 led  output  LED_NUM  LED drive, 1 = on.
REQ-011 step_pulse  output  1  one-cycle pulse in the same cycle led updates on a pattern step.
REQ-012 mode_cur  output  2  currently active mode.

Function
REQ-013 Prescaler SHALL count 0..DELAY_STEP, wrap to 0, and assert a one-cycle tick when count = DELAY_STEP and pause = 0.
REQ-014 Step counter SHALL count ticks 0..speed; a step occurs on the tick where the counter equals speed, after which it clears to 0.
REQ-015 A speed change SHALL take effect at the next comparison; if the counter already exceeds the new speed, the next tick SHALL produce a step and clear the counter.
REQ-016 While pause = 1, the prescaler, step counter, led, and direction SHALL hold; counting resumes from the held values when pause returns to 0.
REQ-017 Mode 0: on each step, led <= {led[LED_NUM-2:0], led[LED_NUM-1]}.
REQ-018 Mode 1: on each step, led <= {led[0], led[LED_NUM-1:1]}.
REQ-019 Mode 2: a single lit bit SHALL move one position per step in direction dir; dir flips to right on reaching bit LED_NUM-1 and to left on reaching bit 0; the sequence 0,1..N-1,N-2..1,0 has period 2*LED_NUM-2 steps.
REQ-020 Mode 3: on each step, led <= {led[LED_NUM-2:0],1'b1}; when led is all ones, the next step SHALL load led = 1 (bit 0 only).
REQ-021 On mode_vld = 1, mode_cur <= mode, led <= 1, dir <= left, and both prescaler and step counter <= 0 in the next cycle, regardless of pause.
REQ-022 mode_vld SHALL take priority over a coincident step; in that cycle no step is taken and step_pulse = 0.
REQ-023 A mode_vld carrying the current mode SHALL still restart the pattern per REQ-021.
REQ-024 step_pulse SHALL be 0 whenever pause = 1.
REQ-025 The first step after reset or restart SHALL occur (speed+1)*(DELAY_STEP+1) cycles later, absent pause.

Reset
REQ-026 While s_rst_n = 0: led = 1 (bit 0 only), mode_cur = 0, dir = left, step_pulse = 0, and all counters = 0.
REQ-027 Reset asserted mid-step or mid-pattern SHALL take effect immediately and asynchronously; after release, behaviour SHALL equal a fresh start in mode 0.

Structure
REQ-028 Package led_pkg SHALL hold the mode encodings MODE_ROL=0, MODE_ROR=1, MODE_PING=2, MODE_FILL=3 and the dir encodings DIR_LEFT=0, DIR_RIGHT=1.
REQ-029 The prescaler SHALL be a sub-module tick_gen (parameter DELAY_STEP; inputs sclk, s_rst_n, clr, en; output tick).
REQ-030 Pattern next-state logic SHALL be a single combinational case on mode_cur that feeds one registered led/dir stage.

Verification (LED_NUM=4, DELAY_STEP=4, i.e. 5 cycles per tick)
REQ-031 Reset release, speed=0, mode 0 -> led 0001,0010,0100,1000,0001 at cycles 5,10,15,20; one step_pulse each.
REQ-032 mode=2 with mode_vld, speed=1 -> led 0001,0010,0100,1000,0100,0010,0001 at 10-cycle spacing.
REQ-033 mode=3 -> led 0001,0011,0111,1111,0001 per step.
REQ-034 pause high for 13 cycles mid-count -> led and counters frozen, no step_pulse; next step occurs delayed by exactly 13 cycles.
REQ-035 mode_vld (mode=1) in the same cycle as a step -> no step_pulse, led = 0001, mode_cur = 1; the next step gives 1000 five cycles later.
REQ-036 s_rst_n pulsed low while in mode 2 with led = 0100 -> led = 0001 and mode_cur = 0 immediately; rotate-left resumes after release.
